prng_arbiter: RTL and testbench
===============================

PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 SHALL have parameter LEN_W, default 8, giving burst-length width; a length of 0 means 2**LEN_W samples.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 2, per-requester burst request, bit i for requester i.
REQ-005 SHALL have port len0, input, LEN_W, requester 0 burst length.
REQ-006 SHALL have port len1, input, LEN_W, requester 1 burst length.
REQ-007 SHALL have port seed_load, input, 1, loads the step counter from seed.
REQ-008 SHALL have port seed, input, 16, new step-counter value.
REQ-009 SHALL have port out_ready, input, 1, sink accepts the current sample.
REQ-010 SHALL have port out_valid, output, 1, sample present.
REQ-011 SHALL have port out_x, output, 8, x sample.
REQ-012 SHALL have port out_y, output, 8, y sample.
REQ-013 SHALL have port out_step, output, 16, step index of the sample.
REQ-014 SHALL have port out_id, output, 1, requester owning the sample.
REQ-015 SHALL have port out_last, output, 1, final sample of the burst.
REQ-016 SHALL have port grant, output, 2, one-hot current owner; 0 when idle.
REQ-017 SHALL have port busy, output, 1, asserted while in BURST.

Function
REQ-018 SHALL hold a 16-bit step counter S; hi = S[15:8], lo = S[7:0].
REQ-019 SHALL drive out_x = (hi + lo) mod 256 and out_y = (hi + 2*lo) mod 256, combinationally from registered S; out_step = S.
REQ-020 SHALL implement FSM states IDLE and BURST.
REQ-021 IDLE: seed_load=1 SHALL load S <= seed; req is ignored that cycle and the FSM stays in IDLE.
REQ-022 IDLE, seed_load=0, req!=0: SHALL grant round-robin, preferring the requester not served last; a sole requester wins.
REQ-023 On grant: SHALL latch the owner, latch remaining <= len (0 maps to 2**LEN_W), and go to BURST next cycle.
REQ-024 BURST: out_valid=1, grant=onehot(owner), out_id=owner; out_last=1 when remaining==1.
REQ-025 Handshake: a transfer occurs when out_valid and out_ready are both 1; on a transfer S <= S+1 (wraps 0xFFFF->0x0000) and remaining decrements.
REQ-026 With out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-027 A transfer with out_last=1 SHALL return the FSM to IDLE and record the owner as last served; out_valid=0 for at least one cycle between bursts.
REQ-028 In BURST, req and len changes and seed_load SHALL be ignored; the burst always completes.
REQ-029 In IDLE: out_valid=0, out_last=0, grant=0, busy=0; S holds except on seed_load.
REQ-030 S SHALL never advance without a transfer, so each step value is delivered exactly once per counter period.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, S=0, remaining=0, owner=0, last-served=1 (requester 0 wins the first tie), out_valid=0, grant=0, busy=0, out_last=0, out_id=0.
REQ-032 Reset mid-burst SHALL abandon the burst with no further samples; out_step reads 0.

Structure
REQ-033 Package prng_arb_pkg SHALL hold the state enum, NREQ=2, and STEP_W=16.
REQ-034 Sub-module prng_step_mix SHALL implement REQ-019 combinationally (16-bit step in, x/y out).

Verification
REQ-035 Reset; req=01, len0=3, out_ready=1 -> steps 0,1,2; (x,y)=(0,0),(1,2),(2,4); out_last on step 2; grant=01.
REQ-036 After REQ-035, req=11, len0=len1=1 -> requester 1 served first (step 3, x=3, y=6), then requester 0 (step 4); each burst is preceded by an idle cycle.
REQ-037 seed_load, seed=0xFFFF in IDLE; then req=10, len1=2 -> steps 0xFFFF (x=0xFE, y=0xFD), then 0x0000 (x=0, y=0), showing wrap.
REQ-038 Burst active, out_ready=0 for 5 cycles -> out_valid=1 and out_x/out_y/out_step unchanged; S advances only after out_ready=1.
REQ-039 rst_n pulsed low mid-burst -> out_valid=0 and out_step=0 the same cycle; len0=0 afterward yields 256 samples, with out_last on step 255.

Source files
------------

// File: rtl/prng_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prng_arb_pkg
// Brief    : Shared types and constants for the PRNG burst arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package prng_arb_pkg;

    localparam int NREQ   = 2;
    localparam int STEP_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic id);
        return NREQ'(1) << id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prng_step_mix.sv
`default_nettype none
// ============================================================================
// Module   : prng_step_mix
// Brief    : Maps a step index to an (x, y) sample pair.
// Revision : 1.0 - initial release
// ============================================================================
module prng_step_mix
    import prng_arb_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    output logic [7:0]        x,
    output logic [7:0]        y
);

    logic [7:0] w_hi;
    logic [7:0] w_lo;

    assign w_hi = step[15:8];
    assign w_lo = step[7:0];
    assign x    = w_hi + w_lo;
    assign y    = w_hi + {w_lo[6:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/prng_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prng_arbiter
// Brief    : Round-robin burst arbiter streaming step-indexed PRNG samples.
// Revision : 1.0 - initial release
// ============================================================================
module prng_arbiter
    import prng_arb_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic              seed_load,
    input  logic [STEP_W-1:0] seed,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [7:0]        out_x,
    output logic [7:0]        out_y,
    output logic [STEP_W-1:0] out_step,
    output logic              out_id,
    output logic              out_last,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);

    localparam logic [LEN_W:0] c_FULL = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] c_ONE  = {{LEN_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [LEN_W:0]      r_rem;
    logic [LEN_W:0]      w_rem_nxt;
    logic                r_owner;
    logic                w_owner_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic                w_pick;
    logic [LEN_W:0]      w_len0_ext;
    logic [LEN_W:0]      w_len1_ext;
    logic                w_is_last;

    // On a tie, the requester not served last wins.
    assign w_pick     = (req == 2'b11) ? ~r_last : req[1];
    assign w_len0_ext = (len0 == '0) ? c_FULL : {1'b0, len0};
    assign w_len1_ext = (len1 == '0) ? c_FULL : {1'b0, len1};
    assign w_is_last  = (r_rem == c_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_rem   <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_rem   <= w_rem_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_rem_nxt   = r_rem;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_id      = 1'b0;
        grant       = '0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (seed_load) begin
                    w_step_nxt = seed;
                end else if (req != '0) begin
                    w_owner_nxt = w_pick;
                    w_rem_nxt   = w_pick ? w_len1_ext : w_len0_ext;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                out_valid = 1'b1;
                out_last  = w_is_last;
                out_id    = r_owner;
                grant     = onehot(r_owner);
                busy      = 1'b1;
                if (out_ready) begin
                    w_step_nxt = r_step + STEP_W'(1);
                    w_rem_nxt  = r_rem - c_ONE;
                    if (w_is_last) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = r_owner;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign out_step = r_step;

    prng_step_mix u_mix (
        .step (r_step),
        .x    (out_x),
        .y    (out_y)
    );

endmodule
`default_nettype wire

// File: tb/tb_prng_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prng_arbiter
// Brief    : Directed self-checking bench for prng_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prng_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [7:0]  len0;
    logic [7:0]  len1;
    logic        seed_load;
    logic [15:0] seed;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_x;
    logic [7:0]  out_y;
    logic [15:0] out_step;
    logic        out_id;
    logic        out_last;
    logic [1:0]  grant;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    prng_arbiter #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .seed_load (seed_load),
        .seed      (seed),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_step  (out_step),
        .out_id    (out_id),
        .out_last  (out_last),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sample(input string tag, input logic [15:0] st, input logic [7:0] x,
                              input logic [7:0] y, input logic id, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_step"},  32'(out_step),  32'(st));
        chk({tag, "_x"},     32'(out_x),     32'(x));
        chk({tag, "_y"},     32'(out_y),     32'(y));
        chk({tag, "_id"},    32'(out_id),    32'(id));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        chk({tag, "_grant"}, 32'(grant),     id ? 32'd2 : 32'd1);
        chk({tag, "_busy"},  32'(busy),      32'd1);
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] st);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_grant"}, 32'(grant),     32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_step"},  32'(out_step),  32'(st));
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; len0 = 8'd0; len1 = 8'd0;
        seed_load = 1'b0; seed = 16'h0000; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk_idle("rst", 16'h0000);
        chk("rst_id", 32'(out_id), 32'd0);
        rst_n = 1'b1;

        // Sole requester 0, three samples
        @(negedge clk);
        req = 2'b01; len0 = 8'd3; out_ready = 1'b1;
        @(negedge clk);
        req = 2'b00;
        chk_sample("b0s0", 16'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_sample("b0s1", 16'd1, 8'd1, 8'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk_sample("b0s2", 16'd2, 8'd2, 8'd4, 1'b0, 1'b1);
        @(negedge clk);
        chk_idle("b0end", 16'd3);

        // Tie: requester 1 first, then requester 0, idle gap between
        req = 2'b11; len0 = 8'd1; len1 = 8'd1;
        @(negedge clk);
        chk_sample("rr1", 16'd3, 8'd3, 8'd6, 1'b1, 1'b1);
        @(negedge clk);
        chk_idle("rrgap", 16'd4);
        @(negedge clk);
        req = 2'b00;
        chk_sample("rr0", 16'd4, 8'd4, 8'd8, 1'b0, 1'b1);
        @(negedge clk);
        chk_idle("rrend", 16'd5);

        // Seed load ignores req that cycle, then wrap through 0xFFFF
        seed_load = 1'b1; seed = 16'hFFFF; req = 2'b10; len1 = 8'd2;
        @(negedge clk);
        seed_load = 1'b0;
        chk_idle("seed", 16'hFFFF);
        @(negedge clk);
        req = 2'b00;
        chk_sample("wrap0", 16'hFFFF, 8'hFE, 8'hFD, 1'b1, 1'b0);
        @(negedge clk);
        chk_sample("wrap1", 16'h0000, 8'h00, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk_idle("wrapend", 16'h0001);

        // Back-pressure: outputs hold; seed_load/req in BURST are ignored
        req = 2'b01; len0 = 8'd2; out_ready = 1'b0;
        @(negedge clk);
        req = 2'b10; seed_load = 1'b1; seed = 16'h1234; len0 = 8'd9;
        for (int i = 0; i < 5; i++) begin
            chk_sample("stall", 16'd1, 8'd1, 8'd2, 1'b0, 1'b0);
            @(negedge clk);
        end
        req = 2'b00; seed_load = 1'b0; out_ready = 1'b1;
        chk_sample("stall_end", 16'd1, 8'd1, 8'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk_sample("resume", 16'd2, 8'd2, 8'd4, 1'b0, 1'b1);

        // Asynchronous reset mid-burst
        rst_n = 1'b0;
        #1;
        chk_idle("arst", 16'h0000);
        @(negedge clk);
        chk_idle("arst_hold", 16'h0000);
        rst_n = 1'b1; req = 2'b01; len0 = 8'd0; out_ready = 1'b1;

        // len0 = 0 means 256 samples
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 256; i++) begin
            chk("full_valid", 32'(out_valid), 32'd1);
            chk("full_step",  32'(out_step),  32'(i));
            chk("full_last",  32'(out_last),  (i == 255) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk_idle("full_end", 16'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
